// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C target receiver
package i2c_pkg;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h3C;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - bus line synchronizer with stable-count glitch filter and edge pulses
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = $clog2(FILT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_sync;

  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

  // Synchronizer chain; resets high because an idle I2C line is pulled up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '1;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
  end

  // Accept a new level only after it has differed from the current one for FILT_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILT_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= w_sync;
        r_rise  <= w_sync;
        r_fall  <= !w_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_target_rx.sv
// rtl/i2c_target_rx.sv - write-only I2C target: address match, byte receive, open-drain ACK
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR        = I2C_DEFAULT_ADDR,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILT_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  input  logic       rx_ready,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       first_byte,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy
);

  logic       w_scl_f, w_scl_rise, w_scl_fall;
  logic       w_sda_f, w_sda_rise, w_sda_fall;
  logic       w_start, w_stop, w_byte_done, w_addr_hit, w_ack_phase, w_shifting;
  logic [7:0] w_byte;

  i2c_state_e r_state, w_next;
  logic       r_scl_f_d;
  logic [6:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_sda_oe;
  logic [7:0] r_data_out;
  logic       r_data_valid, r_first, r_start_det, r_stop_det, r_busy;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_scl_filt (
    .clk(clk), .rst_n(rst_n), .i_line(scl),
    .o_level(w_scl_f), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_sda_filt (
    .clk(clk), .rst_n(rst_n), .i_line(sda),
    .o_level(w_sda_f), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  // SCL must be high now and one cycle earlier, so an SDA edge alongside an SCL fall is data, not a condition.
  assign w_start     = w_sda_fall && w_scl_f && r_scl_f_d;
  assign w_stop      = w_sda_rise && w_scl_f && r_scl_f_d;
  assign w_byte      = {r_shift, w_sda_f};
  assign w_byte_done = w_scl_rise && (r_bit_cnt == 3'd7);
  assign w_addr_hit  = (w_byte[7:1] == ADDR) && !w_byte[0];
  assign w_ack_phase = (r_state == S_ADDR_ACK) || (r_state == S_DATA_ACK);
  assign w_shifting  = (r_state == S_ADDR) || (r_state == S_DATA);

  assign sda        = r_sda_oe ? 1'b0 : 1'bz;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign first_byte = r_first;
  assign start_det  = r_start_det;
  assign stop_det   = r_stop_det;
  assign busy       = r_busy;

  // State register plus one-cycle-delayed filtered SCL for the START/STOP qualifier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_scl_f_d <= 1'b1;
    end else begin
      r_state   <= w_next;
      r_scl_f_d <= w_scl_f;
    end
  end

  // Next state: bus conditions override everything, otherwise advance on byte end or ACK clock end.
  always_comb begin
    w_next = r_state;
    if (w_start) begin
      w_next = S_ADDR;
    end else if (w_stop) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_ADDR:     if (w_byte_done) w_next = w_addr_hit ? S_ADDR_ACK : S_IGNORE;
        S_DATA:     if (w_byte_done) w_next = rx_ready ? S_DATA_ACK : S_IGNORE;
        S_ADDR_ACK,
        S_DATA_ACK: if (w_scl_fall && r_sda_oe) w_next = S_DATA;
        default:    ;
      endcase
    end
  end

  // Shift bits in MSB first; the counter wraps 7 -> 0 so each byte starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_start || w_stop) begin
      r_bit_cnt <= '0;
    end else if (w_shifting && w_scl_rise) begin
      r_shift   <= w_byte[6:0];
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  // ACK drive: first SCL fall in an ACK state grabs SDA, the next one lets go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_sda_oe <= 1'b0;
    else if (w_start || w_stop)      r_sda_oe <= 1'b0;
    else if (w_ack_phase && w_scl_fall) r_sda_oe <= !r_sda_oe;
  end

  // Consumer-facing strobes, held data byte, first-byte flag and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_first      <= 1'b0;
      r_start_det  <= 1'b0;
      r_stop_det   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_start_det  <= w_start;
      r_stop_det   <= w_stop;
      if (w_start || w_stop) begin
        r_busy <= 1'b0;
      end else begin
        if ((r_state == S_ADDR) && w_byte_done && w_addr_hit) r_busy <= 1'b1;
        if ((r_state == S_DATA) && w_byte_done && rx_ready) begin
          r_data_out   <= w_byte;
          r_data_valid <= 1'b1;
        end
      end
      if (w_start)           r_first <= 1'b1;
      else if (r_data_valid) r_first <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_target_rx.sv
// tb/tb_i2c_target_rx.sv - randomized self-checking bench for i2c_target_rx
`timescale 1ns/1ps
module tb_i2c_target_rx;

  localparam int         Q      = 8;
  localparam logic [6:0] T_ADDR = 7'h3C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       rx_ready = 1'b1;
  wire        sda;
  logic [7:0] data_out;
  logic       data_valid, first_byte, start_det, stop_det, busy;

  assign sda = sda_m ? 1'bz : 1'b0;
  pullup (sda);

  i2c_target_rx #(.ADDR(T_ADDR), .SYNC_STAGES(2), .FILT_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda(sda), .rx_ready(rx_ready),
    .data_out(data_out), .data_valid(data_valid), .first_byte(first_byte),
    .start_det(start_det), .stop_det(stop_det), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  logic [8:0] seen_q[$];
  int         n_start = 0;
  int         n_stop  = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) seen_q.push_back({first_byte, data_out});
      if (start_det)  n_start++;
      if (stop_det)   n_stop++;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b, input bit glitch, output bit s);
    clks(Q);
    sda_m = b;
    if (glitch) begin
      clks(2); scl = 1'b1; clks(2); scl = 1'b0; clks(Q - 4);
    end else begin
      clks(Q);
    end
    scl = 1'b1;
    clks(Q);
    s = sda;
    clks(Q);
    scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gl, output bit ack);
    bit s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], (7 - i) == gl, s);
    send_bit(1'b1, 1'b0, s);
    ack = !s;
  endtask

  task automatic bus_start();
    if (!scl) begin
      clks(Q); sda_m = 1'b1; clks(Q); scl = 1'b1; clks(Q);
    end
    sda_m = 1'b0;
    clks(Q);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    clks(Q); sda_m = 1'b0; clks(Q); scl = 1'b1; clks(Q); sda_m = 1'b1; clks(Q);
  endtask

  logic [7:0] tx_b[8];
  bit         tx_rdy[8];

  // One full write transfer of n bytes (tx_b[0] is the address byte), checked against a
  // transaction-level model of an ideal write-only target.
  task automatic xfer(input int n, input int gl_byte);
    bit         exp_ack[8];
    logic [8:0] exp_q[$];
    bit         ign, ack;
    int         bs, bp, bq;
    ign = !((tx_b[0][7:1] == T_ADDR) && (tx_b[0][0] == 1'b0));
    exp_ack[0] = !ign;
    for (int i = 1; i < n; i++) begin
      if (ign) exp_ack[i] = 1'b0;
      else if (tx_rdy[i]) begin
        exp_ack[i] = 1'b1;
        exp_q.push_back({exp_q.size() == 0, tx_b[i]});
      end else begin
        exp_ack[i] = 1'b0;
        ign = 1'b1;
      end
    end
    bs = n_start; bp = n_stop; bq = seen_q.size();
    bus_start();
    for (int i = 0; i < n; i++) begin
      rx_ready = tx_rdy[i];
      send_byte(tx_b[i], (i == gl_byte) ? 3 : -1, ack);
      check($sformatf("ack[%0d] byte=%02h", i, tx_b[i]), ack, exp_ack[i]);
      if (i == 0) check("busy_after_addr", busy, exp_ack[0]);
    end
    bus_stop();
    clks(10);
    check("start_count", n_start - bs, 1);
    check("stop_count", n_stop - bp, 1);
    check("busy_after_stop", busy, 0);
    check("strobe_count", seen_q.size() - bq, exp_q.size());
    for (int i = 0; i < exp_q.size() && (bq + i) < seen_q.size(); i++)
      check($sformatf("strobe[%0d]", i), seen_q[bq + i], exp_q[i]);
  endtask

  initial begin
    bit         ack, s;
    int         bs, bp, bq, n, r;
    logic [7:0] pat;

    clks(3);
    check("rst_sda", sda, 1);
    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_first_byte", first_byte, 0);
    check("rst_start_det", start_det, 0);
    check("rst_stop_det", stop_det, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    clks(5);

    tx_b[0] = 8'h78; tx_b[1] = 8'h00; tx_b[2] = 8'hAF;
    tx_rdy[0] = 1; tx_rdy[1] = 1; tx_rdy[2] = 1;
    xfer(3, -1);
    check("data_out_held", data_out, 8'hAF);

    tx_b[0] = 8'h7A; tx_b[1] = 8'h55;
    xfer(2, -1);

    tx_b[0] = 8'h79; tx_b[1] = 8'h12;
    xfer(2, -1);

    tx_b[0] = 8'h78; tx_b[1] = 8'h11; tx_b[2] = 8'h22; tx_b[3] = 8'h33;
    tx_rdy[1] = 1; tx_rdy[2] = 0; tx_rdy[3] = 1;
    xfer(4, -1);
    rx_ready = 1'b1;

    bs = n_start; bp = n_stop; bq = seen_q.size();
    pat = 8'hA5;
    bus_start();
    send_byte(8'h78, -1, ack);
    check("rs_addr_ack", ack, 1);
    for (int i = 0; i < 4; i++) send_bit(pat[7 - i], 1'b0, s);
    bus_start();
    send_byte(8'h78, -1, ack);
    check("rs_addr2_ack", ack, 1);
    send_byte(8'h44, -1, ack);
    check("rs_data_ack", ack, 1);
    bus_stop();
    clks(10);
    check("rs_start_count", n_start - bs, 2);
    check("rs_stop_count", n_stop - bp, 1);
    check("rs_strobe_count", seen_q.size() - bq, 1);
    if (seen_q.size() > bq) check("rs_strobe", seen_q[bq], {1'b1, 8'h44});

    tx_b[0] = 8'h78; tx_b[1] = 8'h5A; tx_b[2] = 8'hC3;
    tx_rdy[1] = 1; tx_rdy[2] = 1;
    xfer(3, 1);

    pat = 8'h78;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(pat[i], 1'b0, s);
    clks(Q); sda_m = 1'b1; clks(Q); scl = 1'b1; clks(Q);
    check("ack_driven_before_rst", sda, 0);
    check("busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midack_rst_sda", sda, 1);
    check("midack_rst_data_out", data_out, 0);
    check("midack_rst_data_valid", data_valid, 0);
    check("midack_rst_first_byte", first_byte, 0);
    check("midack_rst_busy", busy, 0);
    check("midack_rst_start_det", start_det, 0);
    check("midack_rst_stop_det", stop_det, 0);
    clks(3);
    rst_n = 1'b1;
    clks(5);

    for (int t = 0; t < 12; t++) begin
      r = $urandom_range(0, 5);
      case (r)
        0, 1, 2: tx_b[0] = 8'h78;
        3:       tx_b[0] = 8'h79;
        4:       tx_b[0] = 8'h7A;
        default: tx_b[0] = 8'($urandom);
      endcase
      tx_rdy[0] = 1'b1;
      n = $urandom_range(1, 5);
      for (int i = 1; i < n; i++) begin
        tx_b[i]   = 8'($urandom);
        tx_rdy[i] = ($urandom_range(0, 4) != 0);
      end
      xfer(n, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
